reaction_round_ctrl: RTL and testbench
======================================

// Module: reaction_round_ctrl
// PURPOSE
//  Sequences one reaction-time round for the board-level reaction timer:
//  arms on a start press, waits a switch-selected delay, lights the stimulus
//  LED, then measures the time to the response press in 0.01 s units.
//  Sits between the debounced pushbuttons/switches and the BCD/7-seg display path.
//  Flags false starts and timeouts, and optionally tracks the best time.
// PARAMETERS
//  TICK_DIV  500000  clk cycles per 0.01 s tick (50 MHz board clock)
//  MAX_CS    999     saturation/timeout value of the centisecond count (fits 3 digits)
// PORTS
//  clk           in   1   board clock; all logic on posedge
//  key0          in   1   synchronous reset, active-low
//  start         in   1   start button, active-high level, already synchronised
//  react         in   1   response button, active-high level, already synchronised
//  delay_sel     in   8   arming delay in whole seconds (0..255)
//  led           out  1   stimulus LED; high only in STIM
//  busy          out  1   high in ARMED or STIM
//  result        out  10  reaction time in centiseconds, held until next arm
//  result_valid  out  1   high in DONE
//  foul          out  1   high in FOUL (react pressed before stimulus)
//  best          out  10  best (lowest) valid result since reset
//  best_valid    out  1   best holds at least one result
// BEHAVIOUR
//  - Reset (key0==0 at posedge): state=IDLE, every output 0, prescaler/counters 0.
//    Reset is honoured in every state, including mid-round; it overrides all inputs.
//  - Rising edges of start/react are detected internally (registered previous value;
//    previous value resets to 1 so a button held through reset produces no edge).
//  - Prescaler: counts 0..TICK_DIV-1 and emits a 1-cycle tick on wrap; cleared on
//    every state entry and runs only in ARMED/STIM.
//  - cs_cnt: 10-bit centisecond counter, cleared on entry to ARMED and STIM, +1 per tick.
//  - States / transitions (evaluated each posedge, one transition per cycle):
//    IDLE : start edge -> ARMED.
//    ARMED: react edge -> FOUL (priority over the delay expiry in the same cycle);
//           cs_cnt == delay_sel*100 (16-bit compare) -> STIM; delay_sel==0 gives STIM
//           one cycle after entry. start edge ignored.
//    STIM : react edge -> DONE, result <= cs_cnt pre-increment (a tick in the same
//           cycle is discarded); cs_cnt reaches MAX_CS with no react -> DONE,
//           result <= MAX_CS (timeout). start edge ignored.
//    DONE : start edge -> ARMED. FOUL: start edge -> ARMED. react edges ignored.
//  - led is 1 from the first STIM cycle through the last; it drops on the cycle DONE/FOUL
//    is entered. Latency react edge -> result_valid = 1 cycle after the edge is seen.
//  - result clears to 0 on entry to ARMED; foul/result_valid are state-decoded.
//  - cs_cnt never wraps: it saturates at MAX_CS (STIM) and delay compare occurs at
//    most 25500, so the 10-bit counter in ARMED is widened to 15 bits.
// CONFIGURATION
//  REACTION_BEST_TIME_EN defined: on DONE entry, if !best_valid or result<best then
//    best<=result, best_valid<=1; timeouts (result==MAX_CS) never update best; FOUL
//    never updates; best/best_valid clear only on reset.
//  Not defined: no best register; best and best_valid are tied to 0.
// TESTING (bench uses TICK_DIV=4, MAX_CS=999)
//  1 Reset: key0=0 for 2 cycles with start=react=1 -> all outputs 0, IDLE; release -> no arm.
//  2 Normal: delay_sel=1, start edge -> busy=1; led rises after 100 ticks (400 cycles);
//    react edge after 37 ticks -> result=37, result_valid=1, led=0.
//  3 False start: delay_sel=2, react edge at tick 50 of ARMED -> foul=1, led never set,
//    result=0; start edge -> ARMED again with foul=0.
//  4 Timeout: delay_sel=0, no react -> led one cycle after arm, result=999 after
//    999 ticks, best unchanged.
//  5 Best (REACTION_BEST_TIME_EN): rounds 60, 45, 80 -> best=60, 45, 45, best_valid=1;
//    without macro best=0, best_valid=0.
//  6 Reset mid-STIM at tick 10 -> IDLE next cycle, led=0, result=0, best cleared.

Source files
------------

// File: rtl/reaction_round_if.sv
// Button/switch inputs and round status outputs of the reaction-round controller.
// The master drives buttons and delay; the slave (controller) drives LED and results.
interface reaction_round_if;
  logic       start;
  logic       react;
  logic [7:0] delay_sel;
  logic       led;
  logic       busy;
  logic [9:0] result;
  logic       result_valid;
  logic       foul;
  logic [9:0] best;
  logic       best_valid;

  modport master (
    output start, react, delay_sel,
    input  led, busy, result, result_valid, foul, best, best_valid
  );

  modport slave (
    input  start, react, delay_sel,
    output led, busy, result, result_valid, foul, best, best_valid
  );
endinterface

// File: rtl/reaction_round_ctrl.sv
// One reaction-time round: arm, timed delay, stimulus LED, centisecond reaction measurement.
// Define REACTION_BEST_TIME_EN to track the best (lowest) valid result since reset.
module reaction_round_ctrl #(
  parameter int unsigned TICK_DIV = 500000,
  parameter int unsigned MAX_CS   = 999
) (
  input logic              clk,
  input logic              key0,
  reaction_round_if.slave  bus
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [14:0]   CS_MAX    = 15'(MAX_CS);

  typedef enum logic [2:0] {StIdle, StArmed, StStim, StDone, StFoul} state_e;

  state_e        state_q;
  logic [PW-1:0] presc_q;
  logic [14:0]   cs_q;
  logic          start_prev_q, react_prev_q;
  logic          led_q, busy_q, result_valid_q, foul_q;
  logic [9:0]    result_q;

  logic        start_edge, react_edge, tick;
  logic [15:0] delay_cs;

  always_comb begin
    start_edge = bus.start & ~start_prev_q;
    react_edge = bus.react & ~react_prev_q;
    tick       = (presc_q == PRESC_MAX);
    delay_cs   = 16'(bus.delay_sel) * 16'd100;
  end

`ifdef REACTION_BEST_TIME_EN
  logic [9:0] best_q;
  logic       best_valid_q;
  assign bus.best       = best_q;
  assign bus.best_valid = best_valid_q;
`else
  assign bus.best       = '0;
  assign bus.best_valid = 1'b0;
`endif

  assign bus.led          = led_q;
  assign bus.busy         = busy_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.foul         = foul_q;

  always_ff @(posedge clk) begin
    if (!key0) begin
      state_q        <= StIdle;
      presc_q        <= '0;
      cs_q           <= '0;
      // Previous values reset high so a button held through reset gives no edge.
      start_prev_q   <= 1'b1;
      react_prev_q   <= 1'b1;
      led_q          <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      foul_q         <= 1'b0;
      result_q       <= '0;
`ifdef REACTION_BEST_TIME_EN
      best_q         <= '0;
      best_valid_q   <= 1'b0;
`endif
    end else begin
      start_prev_q <= bus.start;
      react_prev_q <= bus.react;
      case (state_q)
        StIdle, StDone, StFoul: begin
          if (start_edge) begin
            state_q        <= StArmed;
            presc_q        <= '0;
            cs_q           <= '0;
            result_q       <= '0;
            busy_q         <= 1'b1;
            result_valid_q <= 1'b0;
            foul_q         <= 1'b0;
          end
        end
        StArmed: begin
          if (react_edge) begin
            state_q <= StFoul;
            presc_q <= '0;
            busy_q  <= 1'b0;
            foul_q  <= 1'b1;
          end else if ({1'b0, cs_q} == delay_cs) begin
            state_q <= StStim;
            presc_q <= '0;
            cs_q    <= '0;
            led_q   <= 1'b1;
          end else begin
            presc_q <= tick ? '0 : presc_q + PW'(1);
            if (tick) cs_q <= cs_q + 15'd1;
          end
        end
        StStim: begin
          if (react_edge || cs_q == CS_MAX) begin
            state_q        <= StDone;
            presc_q        <= '0;
            led_q          <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b1;
            // Reaction takes the pre-increment count; a same-cycle tick is dropped.
            result_q       <= cs_q[9:0];
`ifdef REACTION_BEST_TIME_EN
            if (cs_q != CS_MAX && (!best_valid_q || cs_q[9:0] < best_q)) begin
              best_q       <= cs_q[9:0];
              best_valid_q <= 1'b1;
            end
`endif
          end else begin
            presc_q <= tick ? '0 : presc_q + PW'(1);
            if (tick) cs_q <= cs_q + 15'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Self-checking bench for reaction_round_ctrl (TICK_DIV=4): vector table plus corner sequences.
module tb_reaction_round_ctrl;

`ifdef REACTION_BEST_TIME_EN
  localparam bit BEST_EN = 1'b1;
`else
  localparam bit BEST_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic key0;
  reaction_round_if bus ();

  reaction_round_ctrl #(.TICK_DIV(4), .MAX_CS(999)) dut (
    .clk  (clk),
    .key0 (key0),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       key0, start, react;
    logic [7:0] ds;
    int         n;
    logic       led, busy, valid, foul;
    logic [9:0] res, best;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   passed = 0;

  task automatic add(input logic k, input logic s, input logic r, input logic [7:0] ds,
                     input int n, input logic led, input logic busy, input logic valid,
                     input logic foul, input logic [9:0] res, input logic [9:0] best);
    vec_t v;
    v = '{k, s, r, ds, n, led, busy, valid, foul, res, best};
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [24:0] pack_exp(input logic led, input logic busy, input logic valid,
                                           input logic foul, input logic [9:0] res,
                                           input logic [9:0] best);
    logic [9:0] b;
    b = BEST_EN ? best : 10'd0;
    return {led, busy, valid, foul, res, b, (b != 10'd0)};
  endfunction

  function automatic logic [24:0] pack_act();
    return {bus.led, bus.busy, bus.result_valid, bus.foul, bus.result, bus.best, bus.best_valid};
  endfunction

  task automatic check(input string name, input logic [24:0] act, input logic [24:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h (led,busy,valid,foul,result,best,bv) expected %h",
                  name, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic run_vectors(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      key0          = vecs[i].key0;
      bus.start     = vecs[i].start;
      bus.react     = vecs[i].react;
      bus.delay_sel = vecs[i].ds;
      for (int c = 0; c < vecs[i].n; c++) step();
      check($sformatf("vec%0d", i), pack_act(),
            pack_exp(vecs[i].led, vecs[i].busy, vecs[i].valid, vecs[i].foul,
                     vecs[i].res, vecs[i].best));
    end
  endtask

  initial begin
    int cnt;
    key0 = 1'b0; bus.start = 1'b1; bus.react = 1'b1; bus.delay_sel = 8'd1;

    //  k  s  r  ds   n    led busy val foul res best
    // Reset with buttons held, then release: no arm.
    add(0, 1, 1, 1,   2,   0,  0,   0,  0,   0,  0);   // 0
    add(1, 1, 1, 1,   3,   0,  0,   0,  0,   0,  0);   // 1
    add(1, 0, 0, 1,   1,   0,  0,   0,  0,   0,  0);   // 2
    // Normal round, 1 s delay: LED after 401 edges, react seen with cs=37.
    add(1, 1, 0, 1,   1,   0,  1,   0,  0,   0,  0);   // 3
    add(1, 0, 0, 1,   400, 0,  1,   0,  0,   0,  0);   // 4
    add(1, 0, 0, 1,   1,   1,  1,   0,  0,   0,  0);   // 5
    add(1, 0, 0, 1,   150, 1,  1,   0,  0,   0,  0);   // 6
    add(1, 0, 1, 1,   1,   0,  0,   1,  0,   37, 37);  // 7
    add(1, 0, 0, 1,   2,   0,  0,   1,  0,   37, 37);  // 8
    // False start at tick 50 of a 2 s delay, then re-arm and foul again.
    add(1, 1, 0, 2,   1,   0,  1,   0,  0,   0,  37);  // 9
    add(1, 0, 0, 2,   200, 0,  1,   0,  0,   0,  37);  // 10
    add(1, 0, 1, 2,   1,   0,  0,   0,  1,   0,  37);  // 11
    add(1, 0, 0, 2,   1,   0,  0,   0,  1,   0,  37);  // 12
    add(1, 1, 0, 2,   1,   0,  1,   0,  0,   0,  37);  // 13
    add(1, 0, 1, 2,   1,   0,  0,   0,  1,   0,  37);  // 14
    add(1, 0, 0, 2,   1,   0,  0,   0,  1,   0,  37);  // 15
    // Fresh reset, then best-time rounds 60, 45, 80 with zero delay.
    add(0, 0, 0, 0,   1,   0,  0,   0,  0,   0,  0);   // 16
    add(1, 0, 0, 0,   1,   0,  0,   0,  0,   0,  0);   // 17
    add(1, 1, 0, 0,   1,   0,  1,   0,  0,   0,  0);   // 18
    add(1, 0, 0, 0,   1,   1,  1,   0,  0,   0,  0);   // 19
    add(1, 0, 0, 0,   240, 1,  1,   0,  0,   0,  0);   // 20
    add(1, 0, 1, 0,   1,   0,  0,   1,  0,   60, 60);  // 21
    add(1, 0, 0, 0,   1,   0,  0,   1,  0,   60, 60);  // 22
    add(1, 1, 0, 0,   1,   0,  1,   0,  0,   0,  60);  // 23
    add(1, 0, 0, 0,   1,   1,  1,   0,  0,   0,  60);  // 24
    add(1, 0, 0, 0,   180, 1,  1,   0,  0,   0,  60);  // 25
    add(1, 0, 1, 0,   1,   0,  0,   1,  0,   45, 45);  // 26
    add(1, 0, 0, 0,   1,   0,  0,   1,  0,   45, 45);  // 27
    add(1, 1, 0, 0,   1,   0,  1,   0,  0,   0,  45);  // 28
    add(1, 0, 0, 0,   1,   1,  1,   0,  0,   0,  45);  // 29
    add(1, 0, 0, 0,   320, 1,  1,   0,  0,   0,  45);  // 30
    add(1, 0, 1, 0,   1,   0,  0,   1,  0,   80, 45);  // 31
    add(1, 0, 0, 0,   1,   0,  0,   1,  0,   80, 45);  // 32

    run_vectors(0, 15);

    // Timeout: zero delay, no react; DONE 3997 edges after STIM entry with result 999.
    bus.start = 1'b1; bus.delay_sel = 8'd0;
    step();
    bus.start = 1'b0;
    step();
    check("timeout_led", pack_act(), pack_exp(1, 1, 0, 0, 0, 37));
    cnt = 0;
    while (!bus.result_valid && cnt < 5000) begin
      step();
      cnt++;
    end
    check_int("timeout_cycles", cnt, 3997);
    check("timeout_done", pack_act(), pack_exp(0, 0, 1, 0, 999, 37));
    step();
    check("timeout_hold", pack_act(), pack_exp(0, 0, 1, 0, 999, 37));

    run_vectors(16, 32);

    // Reset at tick 10 of STIM clears everything, including best.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    for (int c = 0; c < 40; c++) step();
    check("midstim_run", pack_act(), pack_exp(1, 1, 0, 0, 0, 45));
    key0 = 1'b0;
    step();
    check("midstim_reset", pack_act(), pack_exp(0, 0, 0, 0, 0, 0));
    key0 = 1'b1;
    step();
    step();
    check("midstim_idle", pack_act(), pack_exp(0, 0, 0, 0, 0, 0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
